// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD limits, converter state encoding and width helper.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_DONE} state_t;

    // Bits needed to hold every value 0 .. 10**ndig-1.
    function automatic int bcd_bin_width(input int ndig);
        longint p = 1;
        for (int i = 0; i < ndig; i++) p = p * 10;
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: valid/ready input and output channels of the BCD-to-binary converter.
interface bcd_to_bin_seq_if #(parameter int NDIG = 3, parameter int BIN_W = 10);

    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] bcd_in;
    logic              out_valid;
    logic              out_ready;
    logic [BIN_W-1:0]  bin_out;
    logic              err;

    modport master(output in_valid, bcd_in, out_ready, input in_ready, out_valid, bin_out, err);
    modport slave(input in_valid, bcd_in, out_ready, output in_ready, out_valid, bin_out, err);

endinterface

// File: rtl/bcd_digit_mac.sv
// bcd_digit_mac: one decimal shift-and-add step (acc*10 + d) plus non-BCD digit flag.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int W = 14
) (
    input  logic [W-1:0] acc,
    input  logic [3:0]   d,
    output logic [W-1:0] acc_next,
    output logic         d_bad
);

    assign acc_next = (acc << 3) + (acc << 1) + {{(W-4){1'b0}}, d};
    assign d_bad    = d > BCD_MAX;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative BCD-to-binary converter, one digit per clock, MSD first.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG  = 3,
    parameter int BIN_W = 10
) (
    input logic             clk,
    input logic             rst,
    bcd_to_bin_seq_if.slave bus
);

    localparam int AW = BIN_W + 4;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    if (BIN_W < bcd_bin_width(NDIG)) begin : g_width_chk
        $error("BIN_W too narrow for NDIG digits");
    end

    state_t            state;
    logic [4*NDIG-1:0] cap;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_next;
    logic [IW-1:0]     idx;
    logic [3:0]        d;
    logic              d_bad;

    assign d = cap[4*idx +: 4];

    bcd_digit_mac #(.W(AW)) u_mac (
        .acc      (acc),
        .d        (d),
        .acc_next (acc_next),
        .d_bad    (d_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.bin_out   <= '0;
            bus.err       <= 1'b0;
            acc           <= '0;
            idx           <= '0;
            cap           <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.in_valid) begin
                    cap          <= bus.bcd_in;
                    acc          <= '0;
                    idx          <= LAST;
                    bus.err      <= 1'b0;
                    bus.in_ready <= 1'b0;
                    state        <= ST_CONV;
                end
                ST_CONV: begin
                    acc <= acc_next;
                    if (d_bad) bus.err <= 1'b1;
                    // Last digit: publish result, forcing zero if any nibble was bad.
                    if (idx == '0) begin
                        state         <= ST_DONE;
                        bus.out_valid <= 1'b1;
                        bus.bin_out   <= (bus.err | d_bad) ? '0 : acc_next[BIN_W-1:0];
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                ST_DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: randomized and directed checks of bcd_to_bin_seq against a decimal reference model.
module tb_bcd_to_bin_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq_if #(.NDIG(3), .BIN_W(10)) bus ();

    bcd_to_bin_seq #(.NDIG(3), .BIN_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: value = sum of digit*10**position; any nibble above 9 gives err and zero.
    function automatic void ref_model(input logic [11:0] v, output int val, output logic e);
        int w = 1;
        val = 0;
        e   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int n = int'(v[4*i +: 4]);
            if (n > 9) e = 1'b1;
            val = val + n * w;
            w   = w * 10;
        end
        if (e) val = 0;
    endfunction

    task automatic send(input logic [11:0] v);
        for (int i = 0; i < 20 && !bus.in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.bcd_in   = v;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from the accepting edge until out_valid is seen; -1 if never.
    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bin_out !== 10'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b bin_out=%0d err=%b, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.bin_out, bus.err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [11:0] vals[5] = '{12'h999, 12'h198, 12'h000, 12'h1A3, 12'h042};
        int          want_v[5] = '{999, 198, 0, 0, 42};
        logic        want_e[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int          cyc;
        for (int i = 0; i < 5; i++) begin
            send(vals[i]);
            wait_out(cyc);
            checks++;
            if (cyc != 3 || int'(bus.bin_out) != want_v[i] || bus.err !== want_e[i]) begin
                errors++;
                $display("FAIL directed %h: lat=%0d bin_out=%0d err=%b, want lat=3 bin_out=%0d err=%b",
                         vals[i], cyc, bus.bin_out, bus.err, want_v[i], want_e[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL directed_release %h: out_valid=%b in_ready=%b, want 0 1",
                         vals[i], bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [11:0] v;
        int          want_v;
        logic        want_e;
        int          cyc;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 3; i++)
                v[4*i +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(0, 15));
            ref_model(v, want_v, want_e);
            send(v);
            wait_out(cyc);
            checks++;
            if (cyc != 3 || int'(bus.bin_out) != want_v || bus.err !== want_e) begin
                errors++;
                $display("FAIL random %h: lat=%0d bin_out=%0d err=%b, want lat=3 bin_out=%0d err=%b",
                         v, cyc, bus.bin_out, bus.err, want_v, want_e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.out_ready = 1'b0;
        send(12'h521);
        wait_out(cyc);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.bin_out !== 10'd521 || bus.err !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: out_valid=%b bin_out=%0d err=%b in_ready=%b, want 1 521 0 0",
                         i, bus.out_valid, bus.bin_out, bus.err, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_hold_valid();
        int cyc;
        bool_busy: begin
            bus.in_valid = 1'b1;
            bus.bcd_in   = 12'h123;
            @(posedge clk);
            #1;
            bus.bcd_in = 12'h456;
        end
        wait_out(cyc);
        checks++;
        if (cyc != 3 || bus.bin_out !== 10'd123) begin
            errors++;
            $display("FAIL hold_first: lat=%0d bin_out=%0d, want lat=3 bin_out=123", cyc, bus.bin_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_out(cyc);
        checks++;
        if (cyc != 3 || bus.bin_out !== 10'd456) begin
            errors++;
            $display("FAIL hold_second: lat=%0d bin_out=%0d, want lat=3 bin_out=456", cyc, bus.bin_out);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(12'h777);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.bin_out !== 10'd0) begin
            errors++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b bin_out=%0d, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.bin_out);
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_out(cyc);
        checks++;
        if (cyc != -1) begin
            errors++;
            $display("FAIL reset_stale: out_valid seen after %0d cycles, want none", cyc);
        end
        send(12'h305);
        wait_out(cyc);
        checks++;
        if (cyc != 3 || bus.bin_out !== 10'd305 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_next: lat=%0d bin_out=%0d err=%b, want lat=3 bin_out=305 err=0",
                     cyc, bus.bin_out, bus.err);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_hold_valid();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
